melay_machine: RTL and testbench

MELAY_MACHINE -- requirements
Module: melay_machine

---
 rtl/melay_machine.sv | 97 +++++++++
 tb/tb_melay_machine.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/melay_machine.sv
// Purpose : Mealy sequencer that launches sub-units A, B and C in order and pulses done at the end.
// Latency : all outputs are combinational from the current state and inputs; minimum sequence is 4 cycles.
// Backpressure: none; each wait state holds until its done input arrives, and unrelated inputs are ignored.
//
// Ports:
//   clk      - single clock, state updates on rising edge
//   reset    - asynchronous, active-high; forces IDLE and silences all outputs
//   start    - request to run the A->B->C sequence (honoured only in IDLE)
//   done_a   - completion from sub-unit A (honoured only in WAIT_A)
//   done_b   - completion from sub-unit B (honoured only in WAIT_B)
//   done_c   - completion from sub-unit C (honoured only in WAIT_C)
//   start_a  - launch pulse to A, coincident with start in IDLE
//   start_b  - launch pulse to B, coincident with done_a in WAIT_A
//   start_c  - launch pulse to C, coincident with done_b in WAIT_B
//   done     - sequence-complete pulse, coincident with done_c in WAIT_C
module melay_machine (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic done_a,
    input  logic done_b,
    input  logic done_c,
    output logic start_a,
    output logic start_b,
    output logic start_c,
    output logic done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_A = 2'd1,
        WAIT_B = 2'd2,
        WAIT_C = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Each state watches exactly one input; the matching output fires in the
    // same cycle and the state advances on the following edge, so a held
    // input produces only a single-cycle pulse.
    always_comb begin
        state_nxt = state;
        start_a   = 1'b0;
        start_b   = 1'b0;
        start_c   = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    start_a   = 1'b1;
                    state_nxt = WAIT_A;
                end
            end
            WAIT_A: begin
                if (done_a) begin
                    start_b   = 1'b1;
                    state_nxt = WAIT_B;
                end
            end
            WAIT_B: begin
                if (done_b) begin
                    start_c   = 1'b1;
                    state_nxt = WAIT_C;
                end
            end
            WAIT_C: begin
                // A coincident start is dropped here; it must be seen again in IDLE.
                if (done_c) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // The state register clears asynchronously, but start can still be
        // high in IDLE while reset is asserted, so the outputs are gated too.
        if (reset) begin
            start_a = 1'b0;
            start_b = 1'b0;
            start_c = 1'b0;
            done    = 1'b0;
        end
    end

endmodule

// File: tb/tb_melay_machine.sv
// Purpose : self-checking bench for melay_machine; directed scenarios then random stimulus.
// Latency : one step per clock; inputs change on the falling edge, outputs sampled 1 time unit later.
// Backpressure: n/a (bench drives all inputs freely).
module tb_melay_machine;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic done_a = 1'b0;
    logic done_b = 1'b0;
    logic done_c = 1'b0;
    logic start_a;
    logic start_b;
    logic start_c;
    logic done;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: index of the sequence stage currently awaited.
    // 0 = waiting for start, 1 = done_a, 2 = done_b, 3 = done_c.
    // Output k (start_a, start_b, start_c, done) fires when input k is high
    // while stage k is awaited; stage then advances modulo 4.
    int stage = 0;

    melay_machine dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .done_a  (done_a),
        .done_b  (done_b),
        .done_c  (done_c),
        .start_a (start_a),
        .start_b (start_b),
        .start_c (start_c),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: outputs {done,start_c,start_b,start_a} observed %b expected %b", tag, got, exp);
        end
    endtask

    // One clock of stimulus: apply inputs on the falling edge, compare the
    // combinational outputs shortly after, then advance the model at the
    // rising edge using the inputs that the DUT saw there.
    task automatic step(input logic r, input logic s, input logic da,
                        input logic db, input logic dc, input string tag);
        logic [3:0] ins;
        logic [3:0] exp;
        @(negedge clk);
        reset  = r;
        start  = s;
        done_a = da;
        done_b = db;
        done_c = dc;
        #1;
        ins = {dc, db, da, s};
        exp = 4'b0000;
        if (!r && ins[stage]) exp[stage] = 1'b1;
        check(tag, {done, start_c, start_b, start_a}, exp);
        @(posedge clk);
        if (r) stage = 0;
        else if (ins[stage]) stage = (stage + 1) % 4;
    endtask

    initial begin
        // Reset held with every input high: outputs must stay silent.
        step(1, 1, 1, 1, 1, "reset_all_inputs_high");
        step(1, 1, 0, 0, 0, "reset_start_high");

        // Nominal sequence; start in the first cycle after reset is honoured.
        step(0, 1, 0, 0, 0, "nom_start_a");
        step(0, 0, 0, 0, 0, "nom_gap0");
        step(0, 0, 1, 0, 0, "nom_start_b");
        step(0, 0, 0, 0, 0, "nom_gap1");
        step(0, 0, 0, 1, 0, "nom_start_c");
        step(0, 0, 0, 0, 0, "nom_gap2");
        step(0, 0, 0, 0, 1, "nom_done");
        for (int i = 0; i < 15; i++) step(0, 0, 0, 0, 0, "nom_idle");

        // Back-to-back minimum latency.
        step(0, 1, 0, 0, 0, "b2b_start_a");
        step(0, 0, 1, 0, 0, "b2b_start_b");
        step(0, 0, 0, 1, 0, "b2b_start_c");
        step(0, 0, 0, 0, 1, "b2b_done");

        // Out-of-order inputs are ignored.
        step(0, 1, 0, 0, 0, "ooo_start_a");
        step(0, 0, 0, 1, 0, "ooo_done_b_in_wait_a");
        step(0, 0, 0, 0, 1, "ooo_done_c_in_wait_a");
        step(0, 1, 0, 0, 0, "ooo_start_in_wait_a");
        step(0, 0, 1, 0, 0, "ooo_start_b");
        step(0, 1, 0, 0, 0, "ooo_start_in_wait_b");
        step(0, 0, 0, 0, 1, "ooo_done_c_in_wait_b");

        // Mid-sequence reset in WAIT_B with done_b high: outputs 0 at once,
        // then the aborted sequence never produces done.
        step(1, 0, 0, 1, 0, "midrst_asserted");
        step(0, 0, 0, 1, 1, "midrst_stale_done");
        step(0, 0, 0, 0, 1, "midrst_no_done");
        step(0, 1, 0, 0, 0, "midrst_new_start_a");
        step(0, 0, 1, 0, 0, "midrst_start_b");
        step(0, 0, 0, 1, 0, "midrst_start_c");
        step(0, 0, 0, 0, 1, "midrst_done");

        // Held start: only one start_a pulse; FSM then waits in WAIT_A.
        step(0, 1, 0, 0, 0, "held_start_c1");
        step(0, 1, 0, 0, 0, "held_start_c2");
        step(0, 1, 0, 0, 0, "held_start_c3");
        step(0, 0, 1, 0, 0, "held_start_b");
        step(0, 0, 0, 1, 0, "held_start_c");

        // done_c together with start in WAIT_C: done only, then start relaunches.
        step(0, 1, 0, 0, 1, "sim_done_only");
        step(0, 1, 0, 0, 0, "sim_start_a_next");
        step(0, 0, 1, 0, 0, "sim_start_b");
        step(0, 0, 0, 1, 0, "sim_start_c");
        step(0, 0, 0, 0, 1, "sim_done");

        // Random stimulus against the stage model.
        for (int i = 0; i < 400; i++) begin
            logic r;
            r = ($urandom_range(0, 31) == 0);
            step(r, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), "random");
        end

        // Final reset with all inputs high.
        step(1, 1, 1, 1, 1, "final_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
